pulse_width_meter: RTL



---
 rtl/pulse_meter_pkg.sv | 17 +
 rtl/dav_rfd_tx.sv | 53 +++++
 rtl/pulse_width_meter.sv | 118 +++++++++++
 3 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse width meter slice.
// Measure/output FSM state enums and the default data width.
package pulse_meter_pkg;

  localparam int PWM_W = 8;

  typedef enum logic {
    M_IDLE,
    M_COUNT
  } mstate_t;

  typedef enum logic {
    O_IDLE,
    O_VALID
  } ostate_t;

endpackage

// File: rtl/dav_rfd_tx.sv
// dav_/rfd four-phase transmitter: moves hold into numero/sat.
// Ports: clock, reset, hold_full/hold_cnt/hold_sat in, rfd in,
// take out (hold drained this edge), numero/sat/dav_ out.
module dav_rfd_tx
  import pulse_meter_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         hold_full,
  input  logic [W-1:0] hold_cnt,
  input  logic         hold_sat,
  input  logic         rfd,
  output logic         take,
  output logic [W-1:0] numero,
  output logic         sat,
  output logic         dav_
);

  ostate_t state;

  assign take = (state == O_IDLE)
              & hold_full & rfd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= O_IDLE;
      numero <= '0;
      sat    <= 1'b0;
      dav_   <= 1'b1;
    end else begin
      unique case (state)
        O_IDLE: begin
          if (take) begin
            numero <= hold_cnt;
            sat    <= hold_sat;
            dav_   <= 1'b0;
            state  <= O_VALID;
          end
        end
        O_VALID: begin
          if (!rfd) begin
            dav_  <= 1'b1;
            state <= O_IDLE;
          end
        end
        default: state <= O_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high pulses on in and hands widths out over dav_/rfd.
// Ports: clock, reset, in, rfd -> numero, sat, dav_, ovr.
// PULSE_METER_SYNC_EN adds a two-flop synchronizer on in.
module pulse_width_meter
  import pulse_meter_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  input  logic         rfd,
  output logic [W-1:0] numero,
  output logic         sat,
  output logic         dav_,
  output logic         ovr
);

  localparam logic [W-1:0] CMAX = {W{1'b1}};

  logic s;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clock) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], in};
  end

  assign s = sync[1];
`else
  assign s = in;
`endif

  mstate_t      mstate;
  logic [W-1:0] count;
  logic         sat_pend;
  logic         armed;
  logic         hold_full;
  logic [W-1:0] hold_cnt;
  logic         hold_sat;
  logic         take;
  logic         cap;

  // A pulse ends on the first low sample seen while counting.
  assign cap = (mstate == M_COUNT) & ~s;

  // A pulse high at reset release must be skipped entirely.
  always_ff @(posedge clock) begin
    if (reset)   armed <= 1'b0;
    else if (!s) armed <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mstate   <= M_IDLE;
      count    <= '0;
      sat_pend <= 1'b0;
    end else begin
      unique case (mstate)
        M_IDLE: begin
          if (s && armed) begin
            count    <= {{(W-1){1'b0}}, 1'b1};
            sat_pend <= (W == 1);
            mstate   <= M_COUNT;
          end
        end
        M_COUNT: begin
          if (s) begin
            if (count != CMAX) begin
              count <= count + 1'b1;
              if (count == CMAX - 1'b1)
                sat_pend <= 1'b1;
            end
          end else begin
            mstate <= M_IDLE;
          end
        end
        default: mstate <= M_IDLE;
      endcase
    end
  end

  // Capture into a drained-this-edge slot is allowed.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_cnt  <= '0;
      hold_sat  <= 1'b0;
      ovr       <= 1'b0;
    end else if (cap && (!hold_full || take)) begin
      hold_full <= 1'b1;
      hold_cnt  <= count;
      hold_sat  <= sat_pend;
    end else if (cap) begin
      ovr <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

  dav_rfd_tx #(
    .W(W)
  ) u_tx (
    .clock    (clock),
    .reset    (reset),
    .hold_full(hold_full),
    .hold_cnt (hold_cnt),
    .hold_sat (hold_sat),
    .rfd      (rfd),
    .take     (take),
    .numero   (numero),
    .sat      (sat),
    .dav_     (dav_)
  );

endmodule
